serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//   Parametrised multi-cycle subtractor: computes diff = a - b - borrow_in, LSB digit first.
//   Each cycle retires DIGIT bits through a chain of 1-bit full subtractors.
//   Successor to the combinational half/full subtractors; trades latency for area.
//   Start/busy/done handshake; also reports unsigned borrow and signed overflow.
// PARAMETERS
//   WIDTH  8  operand/result width in bits, >= 2
//   DIGIT  1  bits processed per cycle; WIDTH % DIGIT == 0 (elaboration-time check)
// PORTS
//   clk         in   1      single clock, rising edge
//   rst         in   1      synchronous, active-high reset
//   start       in   1      request; accepted only while busy==0
//   a           in   WIDTH  minuend; sampled on the accepting edge only
//   b           in   WIDTH  subtrahend; sampled on the accepting edge only
//   borrow_in   in   1      initial borrow; sampled on the accepting edge only
//   busy        out  1      high from the accepting edge until done drops
//   done        out  1      one-cycle pulse; result valid
//   diff        out  WIDTH  a - b - borrow_in mod 2^WIDTH
//   borrow_out  out  1      final borrow (unsigned a < b + borrow_in)
//   overflow    out  1      signed overflow of the two's-complement subtraction
// BEHAVIOUR
//   - N = WIDTH/DIGIT digit steps. States: IDLE -> RUN -> DONE -> IDLE.
//   - IDLE: edge with start=1 latches a, b and borrow_in. Clears the digit counter. Goes to RUN.
//   - RUN: each edge subtracts digit cnt (bits cnt*DIGIT+:DIGIT) with the running borrow.
//     It writes that digit of the shift/result register and increments cnt.
//   - RUN exit: the edge processing digit N-1 moves to DONE.
//     The same edge registers diff, borrow_out and overflow.
//   - DONE: lasts exactly one cycle with done=1, then IDLE.
//   - Latency: start accepted at edge k -> done high in the cycle after edge k+N.
//     busy is low again after edge k+N+1.
//   - busy = (state != IDLE); a new start is accepted on the edge after done.
//   - start while busy (RUN or DONE): ignored, not queued; operands are not resampled.
//   - diff, borrow_out and overflow hold their values until the next completion.
//   - overflow = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]), using the latched a and b.
//     borrow_in is included in diff.
//   - Wrap-around: 0 - 0 - 1 gives diff = all ones, borrow_out = 1, overflow = 0.
//   - Reset, including mid-RUN: on the rst edge the state goes to IDLE.
//     cnt, busy, done, diff, borrow_out and overflow all clear to 0. The partial result is discarded.
//   - rst and start on the same edge: rst wins, start is dropped.
//   - Counter width: $clog2(N) with a minimum of 1. When DIGIT == WIDTH, N = 1 (single RUN cycle).
// STRUCTURE
//   - Shared package/include: state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
//     Also the WIDTH%DIGIT legality check macro.
//   - Sub-module full_subtractor_digit #(DIGIT):
//     combinational ripple of DIGIT 1-bit full subtractors.
//     Ports (x, y, bin) -> (d, bout). d = x ^ y ^ bin; bout = (~x & y) | (~(x ^ y) & bin).
//   - Top level: FSM, digit counter, operand registers, borrow register, result register.
// TESTING
//   - WIDTH=8, DIGIT=1: a=5, b=3, bin=0 -> diff=0x02, borrow_out=0, overflow=0.
//     done exactly 9 cycles after the accepting edge.
//   - a=3, b=5, bin=0 -> diff=0xFE, borrow_out=1, overflow=0.
//   - a=0x80, b=0x01 -> diff=0x7F, borrow_out=0, overflow=1.
//     a=0x7F, b=0xFF -> diff=0x80, overflow=1.
//   - a=0, b=0, bin=1 -> diff=0xFF, borrow_out=1.
//     Exhaustive 8-bit sweep against a reference model (a-b-bin).
//   - Hold start=1 throughout a RUN with changing a/b -> result reflects the first operands only.
//     Back-to-back jobs start on the edge after done.
//   - Assert rst at RUN cycle 3 -> busy=0, done=0, diff=0 after that edge.
//     A new job afterwards gives the correct result.
//   - WIDTH=8, DIGIT=4: a=0x10, b=0x01 -> diff=0x0F, done 3 cycles after the accepting edge.
//     DIGIT=8 -> done 2 cycles after it.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared state encoding, sizing helpers and the WIDTH/DIGIT legality check for the serial subtractor.
`timescale 1ns/1ps
`ifndef SERIAL_SUBTRACTOR_PKG_SV
`define SERIAL_SUBTRACTOR_PKG_SV

`define SERIAL_SUB_CHECK_DIGIT(W, D) \
   if ((W) < 2 || (D) < 1 || ((W) % (D)) != 0) begin : g_bad_digit \
      $error("serial_subtractor: WIDTH must be >= 2 and a multiple of DIGIT"); \
   end

package serial_subtractor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic int digit_steps(input int width, input int digit);
      return width / digit;
   endfunction

   // A single-step job still needs a one-bit counter.
   function automatic int cnt_width(input int steps);
      return (steps <= 1) ? 1 : $clog2(steps);
   endfunction

endpackage

`endif

// File: rtl/serial_subtractor_digit.sv
// full_subtractor_digit: combinational ripple of DIGIT one-bit full subtractors, LSB first.
// Zero latency; purely combinational, no flow control.
`timescale 1ns/1ps
module full_subtractor_digit #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] i_x,
   input  logic [DIGIT-1:0] i_y,
   input  logic             i_bin,
   output logic [DIGIT-1:0] o_d,
   output logic             o_bout
);

   logic w_borrow;

   always_comb begin
      w_borrow = i_bin;
      o_d      = '0;
      for (int i = 0; i < DIGIT; i++) begin
         o_d[i]   = i_x[i] ^ i_y[i] ^ w_borrow;
         w_borrow = (~i_x[i] & i_y[i]) | (~(i_x[i] ^ i_y[i]) & w_borrow);
      end
      o_bout = w_borrow;
   end

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle a - b - borrow_in, DIGIT bits per cycle; done pulses WIDTH/DIGIT+1 edges after accept.
// start is only taken while idle; requests during a job are dropped, never queued.
`timescale 1ns/1ps
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_borrow_in,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_diff,
   output logic             o_borrow_out,
   output logic             o_overflow
);

   localparam int N  = digit_steps(WIDTH, DIGIT);
   localparam int CW = cnt_width(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   `SERIAL_SUB_CHECK_DIGIT(WIDTH, DIGIT)

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic             r_borrow;

   logic             w_accept;
   logic             w_step;
   logic             w_last;
   logic [DIGIT-1:0] w_x;
   logic [DIGIT-1:0] w_y;
   logic [DIGIT-1:0] w_d;
   logic             w_bout;
   logic [WIDTH-1:0] w_res_nxt;
   logic             w_ovf;

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               w_state_nxt = ST_RUN;
               w_accept    = 1'b1;
            end
         end
         ST_RUN: begin
            if (w_last) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_step = (r_state == ST_RUN);
   assign w_last = (r_cnt == LAST);
   assign w_x    = r_a[int'(r_cnt) * DIGIT +: DIGIT];
   assign w_y    = r_b[int'(r_cnt) * DIGIT +: DIGIT];

   full_subtractor_digit #(
      .DIGIT (DIGIT)
   ) u_digit (
      .i_x    (w_x),
      .i_y    (w_y),
      .i_bin  (r_borrow),
      .o_d    (w_d),
      .o_bout (w_bout)
   );

   // The final digit is merged here so the result can be registered on the same edge.
   always_comb begin
      w_res_nxt = r_res;
      w_res_nxt[int'(r_cnt) * DIGIT +: DIGIT] = w_d;
   end

   assign w_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_res_nxt[WIDTH-1] != r_a[WIDTH-1]);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_a          <= '0;
         r_b          <= '0;
         r_res        <= '0;
         r_borrow     <= 1'b0;
         o_diff       <= '0;
         o_borrow_out <= 1'b0;
         o_overflow   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_a      <= i_a;
            r_b      <= i_b;
            r_borrow <= i_borrow_in;
            r_cnt    <= '0;
         end else if (w_step) begin
            r_res    <= w_res_nxt;
            r_borrow <= w_bout;
            r_cnt    <= w_last ? '0 : r_cnt + CW'(1);
            if (w_last) begin
               o_diff       <= w_res_nxt;
               o_borrow_out <= w_bout;
               o_overflow   <= w_ovf;
            end
         end
      end
   end

   assign o_busy = (r_state != ST_IDLE);
   assign o_done = (r_state == ST_DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor at WIDTH=8 with DIGIT = 1, 4 and 8 against a cycle-level arithmetic model.
`timescale 1ns/1ps
module tb_serial_subtractor;

   localparam int NDUT = 3;
   localparam int NS [NDUT] = '{8, 2, 1};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [NDUT-1:0]      rst;
   logic [NDUT-1:0]      start;
   logic [NDUT-1:0]      bin;
   logic [NDUT-1:0][7:0] a;
   logic [NDUT-1:0][7:0] b;
   logic [NDUT-1:0]      busy;
   logic [NDUT-1:0]      done;
   logic [NDUT-1:0][7:0] diff;
   logic [NDUT-1:0]      bo;
   logic [NDUT-1:0]      ov;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_d1 (
      .i_clk(clk), .i_rst(rst[0]), .i_start(start[0]), .i_a(a[0]), .i_b(b[0]),
      .i_borrow_in(bin[0]), .o_busy(busy[0]), .o_done(done[0]), .o_diff(diff[0]),
      .o_borrow_out(bo[0]), .o_overflow(ov[0]));

   serial_subtractor #(.WIDTH(8), .DIGIT(4)) u_d4 (
      .i_clk(clk), .i_rst(rst[1]), .i_start(start[1]), .i_a(a[1]), .i_b(b[1]),
      .i_borrow_in(bin[1]), .o_busy(busy[1]), .o_done(done[1]), .o_diff(diff[1]),
      .o_borrow_out(bo[1]), .o_overflow(ov[1]));

   serial_subtractor #(.WIDTH(8), .DIGIT(8)) u_d8 (
      .i_clk(clk), .i_rst(rst[2]), .i_start(start[2]), .i_a(a[2]), .i_b(b[2]),
      .i_borrow_in(bin[2]), .o_busy(busy[2]), .o_done(done[2]), .o_diff(diff[2]),
      .o_borrow_out(bo[2]), .o_overflow(ov[2]));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Model: a job occupies the unit for NS+1 edges after acceptance; result from plain arithmetic.
   bit         m_busy [NDUT];
   bit         m_done [NDUT];
   int         m_left [NDUT];
   logic [7:0] m_a    [NDUT];
   logic [7:0] m_b    [NDUT];
   bit         m_bin  [NDUT];
   logic [7:0] m_diff [NDUT];
   bit         m_bo   [NDUT];
   bit         m_ov   [NDUT];
   int         m_u;
   int         m_s;

   always @(posedge clk) begin
      for (int d = 0; d < NDUT; d++) begin
         if (rst[d]) begin
            m_busy[d] = 1'b0; m_done[d] = 1'b0; m_left[d] = 0;
            m_diff[d] = 8'h00; m_bo[d] = 1'b0; m_ov[d] = 1'b0;
         end else if (!m_busy[d]) begin
            if (start[d]) begin
               m_a[d] = a[d]; m_b[d] = b[d]; m_bin[d] = bin[d];
               m_busy[d] = 1'b1; m_left[d] = NS[d];
            end
         end else if (m_left[d] > 0) begin
            m_left[d] = m_left[d] - 1;
            if (m_left[d] == 0) begin
               m_done[d] = 1'b1;
               m_u = int'(m_a[d]) - int'(m_b[d]) - int'(m_bin[d]);
               m_s = int'($signed(m_a[d])) - int'($signed(m_b[d])) - int'(m_bin[d]);
               m_diff[d] = m_u[7:0];
               m_bo[d]   = (m_u < 0);
               m_ov[d]   = (m_s < -128) || (m_s > 127);
            end
         end else begin
            m_done[d] = 1'b0;
            m_busy[d] = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("busy[%0d]", d), busy[d], m_busy[d]);
            chk($sformatf("done[%0d]", d), done[d], m_done[d]);
            chk($sformatf("diff[%0d]", d), diff[d], m_diff[d]);
            chk($sformatf("borrow_out[%0d]", d), bo[d], m_bo[d]);
            chk($sformatf("overflow[%0d]", d), ov[d], m_ov[d]);
         end
      end
   end

   task automatic wait_done(input int d, output int lat);
      lat = 1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (done[d] === 1'b1) return;
         @(posedge clk);
         lat++;
      end
      n_vec++;
      n_err++;
      $display("FAIL timeout[%0d]: done not seen, required within 50 cycles", d);
      lat = -1;
   endtask

   task automatic run_job(input int d, input logic [7:0] ta, input logic [7:0] tb,
                          input logic tbin, output int lat);
      @(negedge clk);
      a[d] = ta; b[d] = tb; bin[d] = tbin; start[d] = 1'b1;
      @(posedge clk);
      #1 start[d] = 1'b0;
      wait_done(d, lat);
   endtask

   task automatic expect_res(input int d, input string nm, input logic [7:0] ed,
                             input logic ebo, input logic eov);
      chk({nm, ".diff"}, diff[d], ed);
      chk({nm, ".borrow"}, bo[d], ebo);
      chk({nm, ".ovf"}, ov[d], eov);
   endtask

   initial begin
      int lat;
      bit seen;
      rst = '1; start = '0; bin = '0; a = '0; b = '0;
      @(posedge clk);
      #1 chk_en = 1'b1;
      @(posedge clk);
      #1 rst = '0;
      @(negedge clk);
      chk("reset.busy", busy[0], 1'b0);
      chk("reset.done", done[0], 1'b0);
      chk("reset.diff", diff[0], 8'h00);

      run_job(0, 8'h05, 8'h03, 1'b0, lat);
      chk("d1.latency", lat, 9);
      expect_res(0, "5-3", 8'h02, 1'b0, 1'b0);
      run_job(0, 8'h03, 8'h05, 1'b0, lat);
      expect_res(0, "3-5", 8'hFE, 1'b1, 1'b0);
      run_job(0, 8'h80, 8'h01, 1'b0, lat);
      expect_res(0, "80-01", 8'h7F, 1'b0, 1'b1);
      run_job(0, 8'h7F, 8'hFF, 1'b0, lat);
      expect_res(0, "7F-FF", 8'h80, 1'b1, 1'b1);
      run_job(0, 8'h00, 8'h00, 1'b1, lat);
      expect_res(0, "0-0-1", 8'hFF, 1'b1, 1'b0);

      // start held high with operands churning; only the first operands may count.
      @(negedge clk);
      a[0] = 8'h5A; b[0] = 8'h33; bin[0] = 1'b0; start[0] = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (done[0] === 1'b1) seen = 1'b1;
         else begin a[0] = 8'($urandom); b[0] = 8'($urandom); bin[0] = 1'($urandom); end
      end
      chk("hold.done_seen", seen, 1'b1);
      expect_res(0, "hold", 8'h27, 1'b0, 1'b0);
      a[0] = 8'h10; b[0] = 8'h20; bin[0] = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 start[0] = 1'b0;
      chk("b2b.busy", busy[0], 1'b1);
      wait_done(0, lat);
      expect_res(0, "b2b", 8'hF0, 1'b1, 1'b0);

      // Reset in the third RUN cycle, then reset colliding with start.
      @(negedge clk);
      a[0] = 8'h9C; b[0] = 8'h21; start[0] = 1'b1;
      @(posedge clk);
      #1 start[0] = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst[0] = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst.busy", busy[0], 1'b0);
      chk("midrst.done", done[0], 1'b0);
      chk("midrst.diff", diff[0], 8'h00);
      start[0] = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_start.busy", busy[0], 1'b0);
      rst[0] = 1'b0; start[0] = 1'b0;
      run_job(0, 8'h9C, 8'h21, 1'b0, lat);
      expect_res(0, "after_rst", 8'h7B, 1'b0, 1'b1);

      run_job(1, 8'h10, 8'h01, 1'b0, lat);
      chk("d4.latency", lat, 3);
      expect_res(1, "d4.10-01", 8'h0F, 1'b0, 1'b0);
      run_job(1, 8'h00, 8'h01, 1'b1, lat);
      expect_res(1, "d4.0-1-1", 8'hFE, 1'b1, 1'b0);
      run_job(2, 8'h10, 8'h01, 1'b0, lat);
      chk("d8.latency", lat, 2);
      expect_res(2, "d8.10-01", 8'h0F, 1'b0, 1'b0);
      run_job(2, 8'h80, 8'h01, 1'b0, lat);
      expect_res(2, "d8.80-01", 8'h7F, 1'b0, 1'b1);

      // Coarse sweep including 0x00 and 0xFF on every digit width; the model checks each cycle.
      for (int ia = 0; ia < 256; ia += 17) begin
         for (int ib = 0; ib < 256; ib += 17) begin
            for (int ic = 0; ic < 2; ic++) begin
               for (int d = 0; d < NDUT; d++) begin
                  run_job(d, 8'(ia), 8'(ib), 1'(ic), lat);
               end
            end
         end
      end

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish within 5 ms");
      $fatal(1);
   end

endmodule
